// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for 800x600@72 Hz VGA, one pixel per 50 MHz clock.
// Scan coordinates (xpos/ypos/valid) go to the game controller undelayed.
// hsync/vsync/de go to the connector through a PIPE_DLY-stage delay line so
// they line up with the controller's registered rgb.
//
// Ports:
//   clk_50m      in   1   system/pixel clock
//   rst          in   1   synchronous, active-high reset (priority over en)
//   en           in   1   pixel advance enable; 0 freezes the raster
//   xpos         out  11  horizontal counter
//   ypos         out  11  vertical counter
//   valid        out  1   inside the visible area, undelayed
//   hsync        out  1   horizontal sync, SYNC_POL polarity, delayed
//   vsync        out  1   vertical sync, SYNC_POL polarity, delayed
//   de           out  1   valid, delayed
//   frame_start  out  1   en at position (0,0)
//   line_start   out  1   en at xpos 0
//   frame_cnt    out  16  completed frames, wraps
// ----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 56,
   parameter int   H_SYNC   = 120,
   parameter int   H_BP     = 64,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FP     = 37,
   parameter int   V_SYNC   = 6,
   parameter int   V_BP     = 23,
   parameter logic SYNC_POL = 1'b1,
   parameter int   PIPE_DLY = 1
) (
   input  logic        clk_50m,
   input  logic        rst,
   input  logic        en,
   output logic [10:0] xpos,
   output logic [10:0] ypos,
   output logic        valid,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start,
   output logic        line_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   // Delay-line word is {hsync, vsync, de} with polarity already applied.
   localparam logic [2:0] IDLE_WORD = {~SYNC_POL, ~SYNC_POL, 1'b0};

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic [15:0] frame_q;
   logic        hs_raw;
   logic        vs_raw;
   logic        valid_raw;
   logic [2:0]  out_word;

   // -------------------------------------------------------------------------
   // Raster counters
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_50m) begin
      // NOTE: state is assigned with <= so every register samples the
      // pre-edge values; = here would let later lines see half-updated state.
      if (rst) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         frame_q <= '0;
      end else if (en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt   <= '0;
               frame_q <= frame_q + 16'd1;
            end else begin
               v_cnt <= v_cnt + 11'd1;
            end
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Decode (continuous assigns: nothing here can hold a value, so no latch)
   // -------------------------------------------------------------------------
   assign valid_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign hs_raw    = (h_cnt >= HS_START) && (h_cnt < HS_END);
   // vsync spans whole lines, so it decodes from v_cnt alone.
   assign vs_raw    = (v_cnt >= VS_START) && (v_cnt < VS_END);

   assign out_word  = {hs_raw ~^ SYNC_POL, vs_raw ~^ SYNC_POL, valid_raw};

   // -------------------------------------------------------------------------
   // Output delay line: shifts every clock, independent of en, so the
   // connector-side signals keep a fixed offset from the controller's rgb.
   // -------------------------------------------------------------------------
   generate
      if (PIPE_DLY == 0) begin : g_direct
         assign {hsync, vsync, de} = out_word;
      end else begin : g_pipe
         logic [2:0] stage [PIPE_DLY];

         always_ff @(posedge clk_50m) begin
            if (rst) begin
               // NOTE: every stage is reset, not just the first, so the
               // connector never sees stale sync/de while the line refills.
               for (int i = 0; i < PIPE_DLY; i++) stage[i] <= IDLE_WORD;
            end else begin
               stage[0] <= out_word;
               for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
            end
         end

         assign {hsync, vsync, de} = stage[PIPE_DLY-1];
      end
   endgenerate

   assign xpos        = h_cnt;
   assign ypos        = v_cnt;
   assign valid       = valid_raw;
   assign frame_cnt   = frame_q;
   assign line_start  = en && (h_cnt == 11'd0);
   assign frame_start = en && (h_cnt == 11'd0) && (v_cnt == 11'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Four generator instances run side by side from one clock:
//   0: default 800x600 geometry, PIPE_DLY=1, SYNC_POL=1
//   1: default geometry, PIPE_DLY=0, SYNC_POL=0
//   2: tiny 15x8 raster, PIPE_DLY=3, SYNC_POL=1 (many frames, vsync, resets)
//   3: 1x1 raster, PIPE_DLY=2, SYNC_POL=0 (frame_cnt reaches its 16-bit wrap)
// The reference model tracks only "pixels advanced since reset" and derives
// every output from that count with division/modulo.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        valid;
      logic        hsync;
      logic        vsync;
      logic        de;
      logic        fs;
      logic        ls;
      logic [15:0] fc;
   } out_t;

   typedef out_t [3:0] out_set_t;

   typedef struct {
      int ha, hf, hs, hb;
      int va, vf, vs, vb;
      bit pol;
      int dly;
   } geom_t;

   localparam int N_CYC = 65600;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_m, en_m, rst_d, en_d;

   logic [10:0] xp [4];
   logic [10:0] yp [4];
   logic [15:0] fcnt [4];
   logic [3:0]  vd, hs, vs, de, fs, ls;

   vga_timing_gen #(.PIPE_DLY(1), .SYNC_POL(1'b1)) dut0 (
      .clk_50m(clk), .rst(rst_m), .en(en_m), .xpos(xp[0]), .ypos(yp[0]),
      .valid(vd[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
      .frame_start(fs[0]), .line_start(ls[0]), .frame_cnt(fcnt[0]));

   vga_timing_gen #(.PIPE_DLY(0), .SYNC_POL(1'b0)) dut1 (
      .clk_50m(clk), .rst(rst_m), .en(en_m), .xpos(xp[1]), .ypos(yp[1]),
      .valid(vd[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
      .frame_start(fs[1]), .line_start(ls[1]), .frame_cnt(fcnt[1]));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .PIPE_DLY(3), .SYNC_POL(1'b1)) dut2 (
      .clk_50m(clk), .rst(rst_m), .en(en_m), .xpos(xp[2]), .ypos(yp[2]),
      .valid(vd[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
      .frame_start(fs[2]), .line_start(ls[2]), .frame_cnt(fcnt[2]));

   vga_timing_gen #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
                    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
                    .PIPE_DLY(2), .SYNC_POL(1'b0)) dut3 (
      .clk_50m(clk), .rst(rst_d), .en(en_d), .xpos(xp[3]), .ypos(yp[3]),
      .valid(vd[3]), .hsync(hs[3]), .vsync(vs[3]), .de(de[3]),
      .frame_start(fs[3]), .line_start(ls[3]), .frame_cnt(fcnt[3]));

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   int         pix [4];          // pixels advanced since last reset
   logic [2:0] hist [4][3];      // {hsync, vsync, de} seen 1,2,3 edges ago
   out_set_t   sb_q [$];
   int         n_checks = 0;
   int         n_errors = 0;

   function automatic geom_t geom(input int c);
      geom_t g;
      case (c)
         2:       g = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 3};
         3:       g = '{1, 0, 0, 0, 1, 0, 0, 0, 1'b0, 2};
         1:       g = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b0, 0};
         default: g = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1};
      endcase
      return g;
   endfunction

   // Connector-side levels for the current raster position, undelayed.
   function automatic logic [2:0] conn_now(input int c);
      geom_t g = geom(c);
      int ht = g.ha + g.hf + g.hs + g.hb;
      int vt = g.va + g.vf + g.vs + g.vb;
      int h  = pix[c] % ht;
      int v  = (pix[c] / ht) % vt;
      bit in_hs = (h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs);
      bit in_vs = (v >= g.va + g.vf) && (v < g.va + g.vf + g.vs);
      bit vis   = (h < g.ha) && (v < g.va);
      logic hl = in_hs ? g.pol : !g.pol;
      logic vl = in_vs ? g.pol : !g.pol;
      return {hl, vl, vis};
   endfunction

   task automatic model_edge(input int c, input logic r, input logic e);
      geom_t g = geom(c);
      if (r) begin
         pix[c] = 0;
         for (int i = 0; i < 3; i++) hist[c][i] = {!g.pol, !g.pol, 1'b0};
      end else begin
         hist[c][2] = hist[c][1];
         hist[c][1] = hist[c][0];
         hist[c][0] = conn_now(c);
         if (e) pix[c] = pix[c] + 1;
      end
   endtask

   function automatic out_t expect_out(input int c, input logic e);
      geom_t g = geom(c);
      out_t o;
      int ht = g.ha + g.hf + g.hs + g.hb;
      int vt = g.va + g.vf + g.vs + g.vb;
      int h  = pix[c] % ht;
      int v  = (pix[c] / ht) % vt;
      logic [2:0] w;
      w       = (g.dly == 0) ? conn_now(c) : hist[c][g.dly-1];
      o.x     = 11'(h);
      o.y     = 11'(v);
      o.valid = (h < g.ha) && (v < g.va);
      o.hsync = w[2];
      o.vsync = w[1];
      o.de    = w[0];
      o.fs    = e && (h == 0) && (v == 0);
      o.ls    = e && (h == 0);
      o.fc    = 16'((pix[c] / (ht * vt)) % 65536);
      return o;
   endfunction

   function automatic out_t actual(input int c);
      out_t o;
      o = '{xp[c], yp[c], vd[c], hs[c], vs[c], de[c], fs[c], ls[c], fcnt[c]};
      return o;
   endfunction

   task automatic check(input string name, input int c,
                        input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s dut%0d t=%0t: got %0d expected %0d",
                  name, c, $time, got, want);
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus: after each edge, advance the model with the inputs that were
   // applied, pick new inputs, then queue the expected outputs for this cycle.
   // ------------------------------------------------------------------------
   initial begin
      out_set_t s;
      rst_m = 1'b1; en_m = 1'b0; rst_d = 1'b1; en_d = 1'b1;
      for (int c = 0; c < 4; c++) pix[c] = 0;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < 3; c++) model_edge(c, rst_m, en_m);
         model_edge(3, rst_d, en_d);

         if (cyc < 3) begin
            rst_m = 1'b1;                         // frame/line_start follow en
            en_m  = 1'($urandom_range(0, 1));
         end else if (cyc < 2203) begin
            rst_m = 1'b0; en_m = 1'b1;            // two full lines of dut0
         end else if (cyc < 4283) begin
            rst_m = 1'b0; en_m = 1'(cyc % 2);     // en toggles every clock
         end else if (cyc < 12000) begin
            rst_m = ($urandom_range(0, 399) == 0); // occasional mid-frame reset
            en_m  = ($urandom_range(0, 3) != 0);
         end else begin
            rst_m = 1'b0;
            en_m  = ($urandom_range(0, 3) != 0);
         end
         rst_d = (cyc < 2);

         for (int c = 0; c < 3; c++) s[c] = expect_out(c, en_m);
         s[3] = expect_out(3, en_d);
         sb_q.push_back(s);
      end

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", 0, 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // ------------------------------------------------------------------------
   // Monitor: outputs are present every cycle; compare on the falling edge.
   // ------------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            out_set_t e;
            e = sb_q.pop_front();
            for (int c = 0; c < 4; c++) begin
               out_t a;
               a = actual(c);
               check("xpos",        c, 32'(a.x),     32'(e[c].x));
               check("ypos",        c, 32'(a.y),     32'(e[c].y));
               check("valid",       c, 32'(a.valid), 32'(e[c].valid));
               check("hsync",       c, 32'(a.hsync), 32'(e[c].hsync));
               check("vsync",       c, 32'(a.vsync), 32'(e[c].vsync));
               check("de",          c, 32'(a.de),    32'(e[c].de));
               check("frame_start", c, 32'(a.fs),    32'(e[c].fs));
               check("line_start",  c, 32'(a.ls),    32'(e[c].ls));
               check("frame_cnt",   c, 32'(a.fc),    32'(e[c].fc));
            end
         end
      end
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 800x600@72 Hz VGA raster timing directly from the 50 MHz system clock (one pixel per clock). Supplies the `xpos`/`ypos`/`valid` scan coordinates consumed by the game controller. Drives `hsync`/`vsync`/`de` to the VGA connector, delayed by a configurable pipeline depth so that they line up with the controller's registered `rgb`. Also emits frame/line strobes and a frame counter for game-tick and debug use.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (clocks)
- H_SYNC, 120, horizontal sync width (clocks)
- H_BP, 64, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low
- PIPE_DLY, 1, clocks of delay on hsync/vsync/de; legal range 0..3

Ports:
- clk_50m  in  1  system/pixel clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- en  in  1  pixel advance enable; 0 freezes the raster
- xpos  out  11  current horizontal counter h_cnt
- ypos  out  11  current vertical counter v_cnt
- valid  out  1  h_cnt < H_ACTIVE && v_cnt < V_ACTIVE, undelayed
- hsync  out  1  horizontal sync, delayed PIPE_DLY
- vsync  out  1  vertical sync, delayed PIPE_DLY
- de  out  1  valid delayed PIPE_DLY
- frame_start  out  1  pulse: en && h_cnt==0 && v_cnt==0
- line_start  out  1  pulse: en && h_cnt==0
- frame_cnt  out  16  completed frames, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1040. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 666.
- h_cnt counts 0..H_TOTAL-1. On each edge with en=1:
  - if h_cnt==H_TOTAL-1, then h_cnt←0 and v_cnt advances;
  - otherwise h_cnt←h_cnt+1.
- v_cnt counts 0..V_TOTAL-1 and wraps to 0 when it advances from V_TOTAL-1.
- Frame wrap: the edge taking (1039,665) to (0,0) increments frame_cnt (mod 2^16).
- xpos=h_cnt and ypos=v_cnt at all times, blanking included. Both are direct register outputs with no combinational decode.
- Raw sync decode:
  - hs_raw = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. [856,976);
  - vs_raw = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. [637,643), for the entire line.
- Output polarity: hsync = hs_raw XNOR SYNC_POL after delay; vsync likewise.
- Delay line:
  - PIPE_DLY-stage shift register on {hs, vs, valid}; shifts every clock, regardless of en.
  - PIPE_DLY=0 means direct combinational outputs.
- en=0:
  - h_cnt, v_cnt and frame_cnt hold;
  - frame_start and line_start are 0;
  - valid still reflects the held position.
- Reset (rst=1 at an edge):
  - h_cnt=0, v_cnt=0, frame_cnt=0;
  - every delay stage loads the inactive value (sync inactive level, de=0).
- Reset values of outputs while and immediately after rst:
  - xpos=0, ypos=0, valid=1;
  - hsync=vsync=!SYNC_POL, de=0;
  - frame_cnt=0;
  - frame_start=line_start=en.
- rst has priority over en. Reset mid-frame restarts at (0,0) on the next edge, with no partial-frame frame_cnt increment.

## Timing
- With en held at 1 after reset release, the counters after k edges are h_cnt = k mod 1040 and v_cnt = (k div 1040) mod 666.
- Line period is 1040 clocks (20.8 µs). Frame period is 692,640 clocks (≈72.19 Hz).
- hs_raw is high for k mod 1040 in [856,975]; hsync follows PIPE_DLY clocks later.
- de rises PIPE_DLY clocks after valid rises and falls PIPE_DLY clocks after valid falls. It is high for exactly 800 consecutive clocks per active line.
- Alignment with the game controller: `rgb` registered from xpos/ypos at edge n pairs with de/hsync/vsync at PIPE_DLY=1.
- frame_start is high in exactly one clock per frame, coincident with xpos=0, ypos=0.
- frame_cnt changes on the same edge that makes frame_start go high.

## Test plan
- Reset, then en=1 for 1040 clocks (PIPE_DLY=1, SYNC_POL=1):
  - valid high for clocks 0..799;
  - hsync high for clocks 857..976 inclusive;
  - line_start at clocks 0 and 1040;
  - ypos=1 at clock 1040.
- Run 692,640 clocks:
  - vsync high for exactly 6 lines, starting at line 637 plus 1 clock;
  - de high for exactly 480,000 clocks;
  - frame_cnt=1 and frame_start pulse at clock 692,640.
- en toggled 1/0 every clock for 2080 clocks: xpos/ypos advance exactly 1040 positions, with no line_start while en=0.
- rst asserted at (xpos=400, ypos=300) for one edge:
  - next cycle xpos=0, ypos=0, frame_cnt unchanged from 0;
  - de=0 and hsync=0 for PIPE_DLY clocks.
- SYNC_POL=0, PIPE_DLY=0:
  - hsync low exactly when xpos in [856,975] in the same cycle;
  - idle high after reset.
- Preload-free wrap check, frame_cnt 65535→0: run to frame 65536 (or force v/h) and confirm the wrap with no glitch on frame_start.
